filter_ctrl_s_axi_regs: RTL

AXI4-Lite slave register file for the filter control IP: the responder end of the S00_AXI port that the master VIP drives with single-beat writes and reads. It holds four 32-bit read/write control registers at byte offsets 0x0, 0x4, 0x8 and 0xC. It drives their values and per-register write strobes to the filter datapath.

---
 rtl/filter_ctrl_s_axi_regs.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/filter_ctrl_s_axi_regs.sv
// AXI4-Lite slave register file for the filter control IP.
// Four 32-bit read/write control registers at byte offsets 0x0, 0x4, 0x8 and 0xC.
// The register contents and a per-register write pulse are exported to the filter datapath.
module filter_ctrl_s_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [31:0]                   reg0_o,
  output logic [31:0]                   reg1_o,
  output logic [31:0]                   reg2_o,
  output logic [31:0]                   reg3_o,
  output logic [3:0]                    wr_pulse_o
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t    w_state;
  r_state_t    r_state;

  logic [31:0] regs [4];

  logic [1:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  // Protection bits and the byte-lane address bits carry no meaning for this block.
  logic        unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  assign reg0_o = regs[0];
  assign reg1_o = regs[1];
  assign reg2_o = regs[2];
  assign reg3_o = regs[3];

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // The commit happens on whichever edge completes the second of the two write handshakes;
  // the half that arrives on that edge comes from the bus, the other half from the holding regs.
  always_comb begin
    commit  = 1'b0;
    wr_idx  = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx_q;
    wr_data = w_hs ? S_AXI_WDATA : wdata_q;
    wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
    case (w_state)
      W_IDLE:  commit = aw_hs && w_hs;
      W_ADDR:  commit = w_hs;
      W_DATA:  commit = aw_hs;
      default: commit = 1'b0;
    endcase
  end

  // Hold whichever half of a split write arrived first until its partner shows up.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Write channel FSM with registered readies and response valid.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_state       <= W_RESP;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
          end else if (aw_hs) begin
            w_state       <= W_ADDR;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
          end else if (w_hs) begin
            w_state       <= W_DATA;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b0;
          end else begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
        W_ADDR: begin
          if (w_hs) begin
            w_state      <= W_RESP;
            S_AXI_WREADY <= 1'b0;
            S_AXI_BVALID <= 1'b1;
          end
        end
        W_DATA: begin
          if (aw_hs) begin
            w_state       <= W_RESP;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
          end
        end
        default: begin
          if (S_AXI_BREADY) begin
            w_state       <= W_IDLE;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Byte-masked register update and the one-cycle write notification to the datapath.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < 4; k++) regs[k] <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit) begin
        wr_pulse_o <= 4'b0001 << wr_idx;
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read channel FSM; RDATA samples the register before any same-edge commit lands.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state       <= R_DATA;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= regs[S_AXI_ARADDR[3:2]];
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        default: begin
          if (S_AXI_RREADY) begin
            r_state       <= R_IDLE;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
